// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU AXI-lite master: state encoding,
// load/store op codes, AXI response codes and strobe width.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] LSU_OP_B  = 3'd0;
  localparam logic [2:0] LSU_OP_H  = 3'd1;
  localparam logic [2:0] LSU_OP_W  = 3'd2;
  localparam logic [2:0] LSU_OP_BU = 3'd4;
  localparam logic [2:0] LSU_OP_HU = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int STRB_W = 8;

  // Halfword (signed or unsigned) on an odd address, or word off a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    return ((op == LSU_OP_H || op == LSU_OP_HU) && addr_lo[0]) ||
           ((op == LSU_OP_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load formatter: selects the byte/half lane from the raw bus
// word and sign- or zero-extends it; flags op codes that are not loads.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] result,
  output logic        illegal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = raw[8*addr_lo +: 8];
    half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];
    result    = '0;
    illegal   = 1'b0;
    case (op)
      LSU_OP_B:  result = {{24{byte_lane[7]}}, byte_lane};
      LSU_OP_H:  result = {{16{half_lane[15]}}, half_lane};
      LSU_OP_W:  result = raw;
      LSU_OP_BU: result = {24'd0, byte_lane};
      LSU_OP_HU: result = {16'd0, half_lane};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI-lite master for the NPC load/store unit.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  input  logic [1:0]        mem_bresp,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp
);

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MisalignChk = 1'b1;
`else
  localparam bit MisalignChk = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] ext_result;
  logic        ext_illegal;
  logic        aw_hs, w_hs, rd_err;

  lsu_load_extract u_extract (
    .addr_lo (addr_q[1:0]),
    .op      (op_q),
    .raw     (mem_rdata),
    .result  (ext_result),
    .illegal (ext_illegal)
  );

  assign aw_hs  = mem_awvalid && mem_awready;
  assign w_hs   = mem_wvalid && mem_wready;
  assign rd_err = (mem_rresp != AXI_RESP_OKAY) || ext_illegal;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          op_d      = req_op;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b0;
          wdata_d   = '0;
          strb_d    = 4'h0;
          if (req_wen) begin
            case (req_op)
              LSU_OP_B: begin
                wdata_d = {4{req_wdata[7:0]}};
                strb_d  = 4'b0001 << req_addr[1:0];
              end
              LSU_OP_H: begin
                wdata_d = {2{req_wdata[15:0]}};
                strb_d  = 4'b0011 << req_addr[1:0];
              end
              default: begin
                wdata_d = req_wdata;
                strb_d  = 4'hF;
              end
            endcase
          end
          if (MisalignChk && is_misaligned(req_op, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (req_wen) begin
            // Store op codes beyond b/h/w have no defined strobe pattern; reject off-bus.
            if (req_op == LSU_OP_B || req_op == LSU_OP_H || req_op == LSU_OP_W) begin
              state_d = ST_AW_W;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AW_W: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          if (mem_bvalid) begin
            err_d   = (mem_bresp != AXI_RESP_OKAY);
            state_d = ST_DONE;
          end else begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (mem_bvalid) begin
          err_d   = (mem_bresp != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_AR: begin
        if (mem_arready) state_d = ST_R;
      end
      ST_R: begin
        if (mem_rvalid) begin
          err_d   = rd_err;
          rdata_d = rd_err ? '0 : ext_result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_arvalid = (state_q == ST_AR);
  assign mem_rready  = (state_q == ST_R);
  assign mem_awvalid = (state_q == ST_AW_W) && !aw_done_q;
  assign mem_wvalid  = (state_q == ST_AW_W) && !w_done_q;
  assign mem_bready  = (state_q == ST_AW_W) || (state_q == ST_B);
  assign mem_awaddr  = addr_q;
  assign mem_araddr  = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = {4'h0, strb_q};
  assign resp_valid  = (state_q == ST_DONE);
  assign resp_rdata  = (state_q == ST_DONE) ? rdata_q : '0;
  assign resp_err    = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: directed vector table, hand-written
// corner sequences and randomized transactions against a behavioural model.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_awvalid, mem_awready;
  logic [31:0] mem_awaddr;
  logic        mem_wvalid, mem_wready;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid, mem_bready;
  logic [1:0]  mem_bresp;
  logic        mem_arvalid, mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid, mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: lane/extension and store replication expressed with plain arithmetic.
  function automatic void model(input bit wen, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mem,
                                input logic [1:0] resp,
                                output logic [31:0] e_rdata, output bit e_err,
                                output logic [31:0] e_wdata, output logic [3:0] e_strb,
                                output bit e_bus);
    logic [31:0] bval, hval;
    int sh;
    bit mis;
    sh   = int'(addr[1:0]);
    bval = (mem >> (8 * sh)) & 32'hFF;
    hval = (mem >> (16 * (sh / 2))) & 32'hFFFF;
    mis  = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((op == 3'd1 || op == 3'd5) && (sh % 2 != 0)) mis = 1'b1;
    if (op == 3'd2 && sh != 0) mis = 1'b1;
`endif
    e_rdata = 32'd0;
    e_wdata = 32'd0;
    e_strb  = 4'd0;
    e_bus   = !mis;
    e_err   = mis || (resp != 2'b00);
    if (wen) begin
      case (op)
        3'd0: begin e_wdata = (wdata & 32'hFF) * 32'h01010101;   e_strb = 4'((32'h1 << sh)); end
        3'd1: begin e_wdata = (wdata & 32'hFFFF) * 32'h00010001; e_strb = 4'((32'h3 << sh)); end
        default: begin e_wdata = wdata; e_strb = 4'hF; end
      endcase
    end else if (!mis) begin
      case (op)
        3'd0: e_rdata = (bval >= 128) ? bval - 32'd256 : bval;
        3'd1: e_rdata = (hval >= 32768) ? hval - 32'd65536 : hval;
        3'd2: e_rdata = mem;
        3'd4: e_rdata = bval;
        3'd5: e_rdata = hval;
        default: e_err = 1'b1;
      endcase
      if (e_err) e_rdata = 32'd0;
    end
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_wen = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = 0;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rresp = 0;
  endtask

  // Issues one request and acts as the responder; cycle k counts from the accept edge.
  task automatic run_txn(input bit wen, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mem, input logic [1:0] resp,
                         input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                         input int b_dly,
                         output logic [31:0] g_rdata, output logic g_err,
                         output logic [31:0] g_wdata, output logic [7:0] g_strb,
                         output logic [31:0] g_addr, output int lat,
                         output int aw_cnt, output int w_cnt, output bit saw_bus);
    int ar_c, r_c, aw_c, w_c, b_c;
    bit r_ph, b_ph, b_started, aw_ok, w_ok, done;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    r_ph = 0; b_ph = 0; b_started = 0; aw_ok = 0; w_ok = 0; done = 0;
    g_rdata = 0; g_err = 0; g_wdata = 0; g_strb = 0; g_addr = 0;
    lat = -1; aw_cnt = 0; w_cnt = 0; saw_bus = 0;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      idle_inputs();
      if (resp_valid) begin
        lat = k; g_rdata = resp_rdata; g_err = resp_err; done = 1;
      end else begin
        if (r_ph) begin
          mem_rvalid = (r_c >= r_dly); r_c++;
          mem_rdata = mem; mem_rresp = resp;
          if (mem_rvalid && mem_rready) r_ph = 0;
        end
        if (mem_arvalid) begin
          saw_bus = 1; g_addr = mem_araddr;
          mem_arready = (ar_c >= ar_dly); ar_c++;
          if (mem_arready) r_ph = 1;
        end
        if (b_ph) begin
          mem_bvalid = (b_c >= b_dly); b_c++; mem_bresp = resp;
          if (mem_bvalid && mem_bready) b_ph = 0;
        end
        if (mem_awvalid) begin
          saw_bus = 1; g_addr = mem_awaddr; aw_cnt++;
          mem_awready = (aw_c >= aw_dly); aw_c++;
          if (mem_awready) aw_ok = 1;
        end
        if (mem_wvalid) begin
          saw_bus = 1; g_wdata = mem_wdata; g_strb = mem_wstrb; w_cnt++;
          mem_wready = (w_c >= w_dly); w_c++;
          if (mem_wready) w_ok = 1;
        end
        if (aw_ok && w_ok && !b_started) begin b_ph = 1; b_started = 1; end
      end
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("resp_single_pulse", {31'd0, resp_valid}, 32'd0);
  endtask

  typedef struct {
    bit          wen;
    logic [2:0]  op;
    logic [31:0] addr, wdata, mem;
    logic [1:0]  resp;
    logic [31:0] e_rdata;
    bit          e_err;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] g_rdata, g_wdata, g_addr;
  logic        g_err;
  logic [7:0]  g_strb;
  int          lat, aw_cnt, w_cnt;
  bit          saw_bus;
  logic [31:0] e_rdata, e_wdata;
  bit          e_err, e_bus;
  logic [3:0]  e_strb;

  initial begin
    vecs[0]  = '{0, 3'd2, 32'h80000004, 32'h0,        32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 0, 32'h0, 4'h0};
    vecs[1]  = '{0, 3'd0, 32'h80000003, 32'h0,        32'h80123456, 2'b00, 32'hFFFFFF80, 0, 32'h0, 4'h0};
    vecs[2]  = '{0, 3'd4, 32'h80000003, 32'h0,        32'h80123456, 2'b00, 32'h00000080, 0, 32'h0, 4'h0};
    vecs[3]  = '{0, 3'd5, 32'h80000002, 32'h0,        32'h80123456, 2'b00, 32'h00008012, 0, 32'h0, 4'h0};
    vecs[4]  = '{0, 3'd1, 32'h80000000, 32'h0,        32'h1234F00D, 2'b00, 32'hFFFFF00D, 0, 32'h0, 4'h0};
    vecs[5]  = '{0, 3'd0, 32'h80000001, 32'h0,        32'h80123456, 2'b00, 32'h00000034, 0, 32'h0, 4'h0};
    vecs[6]  = '{0, 3'd2, 32'h80000008, 32'h0,        32'h11111111, 2'b10, 32'h00000000, 1, 32'h0, 4'h0};
    vecs[7]  = '{0, 3'd3, 32'h80000000, 32'h0,        32'h11111111, 2'b00, 32'h00000000, 1, 32'h0, 4'h0};
    vecs[8]  = '{1, 3'd1, 32'h80000002, 32'h0000ABCD, 32'h0,        2'b00, 32'h00000000, 0, 32'hABCDABCD, 4'hC};
    vecs[9]  = '{1, 3'd0, 32'h80000001, 32'h1234565A, 32'h0,        2'b00, 32'h00000000, 0, 32'h5A5A5A5A, 4'h2};
    vecs[10] = '{1, 3'd2, 32'h80000008, 32'hCAFEF00D, 32'h0,        2'b00, 32'h00000000, 0, 32'hCAFEF00D, 4'hF};
    vecs[11] = '{1, 3'd2, 32'h80000000, 32'h00000001, 32'h0,        2'b11, 32'h00000000, 1, 32'h00000001, 4'hF};

    rst = 1'b1;
    idle_inputs();
    #12;
    chk("rst_arvalid", {31'd0, mem_arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, mem_awvalid}, 32'd0);
    chk("rst_wvalid",  {31'd0, mem_wvalid},  32'd0);
    chk("rst_bready",  {31'd0, mem_bready},  32'd0);
    chk("rst_rready",  {31'd0, mem_rready},  32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_wstrb", {24'd0, mem_wstrb}, 32'd0);
    chk("rst_awaddr", mem_awaddr, 32'd0);
    chk("rst_araddr", mem_araddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].wen, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mem, vecs[i].resp,
              0, 0, 0, 0, 0, g_rdata, g_err, g_wdata, g_strb, g_addr, lat, aw_cnt, w_cnt, saw_bus);
      chk($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].e_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, g_err}, {31'd0, vecs[i].e_err});
      chk($sformatf("vec%0d_latency", i), lat, 32'd3);
      chk($sformatf("vec%0d_addr", i), g_addr, vecs[i].addr);
      if (vecs[i].wen) begin
        chk($sformatf("vec%0d_wdata", i), g_wdata, vecs[i].e_wdata);
        chk($sformatf("vec%0d_wstrb", i), {24'd0, g_strb}, {28'd0, vecs[i].e_strb});
      end
    end

    // Store with awready held off three cycles and wready immediate.
    run_txn(1, 3'd2, 32'h80000010, 32'h01234567, 32'h0, 2'b00, 0, 0, 3, 0, 0,
            g_rdata, g_err, g_wdata, g_strb, g_addr, lat, aw_cnt, w_cnt, saw_bus);
    chk("awdly_aw_cycles", aw_cnt, 32'd4);
    chk("awdly_w_cycles", w_cnt, 32'd1);
    chk("awdly_latency", lat, 32'd6);
    chk("awdly_err", {31'd0, g_err}, 32'd0);

    // Load with arready and rvalid each delayed; each wait adds one cycle.
    run_txn(0, 3'd2, 32'h80000020, 32'h0, 32'h5555AAAA, 2'b00, 2, 1, 0, 0, 0,
            g_rdata, g_err, g_wdata, g_strb, g_addr, lat, aw_cnt, w_cnt, saw_bus);
    chk("lddly_latency", lat, 32'd6);
    chk("lddly_rdata", g_rdata, 32'h5555AAAA);

    // Store with bvalid delayed two cycles.
    run_txn(1, 3'd0, 32'h80000003, 32'h000000EE, 32'h0, 2'b00, 0, 0, 0, 1, 2,
            g_rdata, g_err, g_wdata, g_strb, g_addr, lat, aw_cnt, w_cnt, saw_bus);
    chk("bdly_latency", lat, 32'd6);
    chk("bdly_wstrb", {24'd0, g_strb}, 32'h8);
    chk("bdly_w_cycles", w_cnt, 32'd2);

    // Reset while waiting in R: outputs drop at once and the request is dropped.
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_op = 3'd2; req_addr = 32'h80000040;
    @(negedge clk);
    idle_inputs();
    chk("rstR_arvalid_seen", {31'd0, mem_arvalid}, 32'd1);
    mem_arready = 1;
    @(negedge clk);
    idle_inputs();
    chk("rstR_rready_seen", {31'd0, mem_rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstR_rready_drop", {31'd0, mem_rready}, 32'd0);
    chk("rstR_arvalid_drop", {31'd0, mem_arvalid}, 32'd0);
    chk("rstR_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (resp_valid) pulses++;
      end
      chk("rstR_no_resp", pulses, 32'd0);
    end
    run_txn(0, 3'd4, 32'h80000042, 32'h0, 32'h00C30000, 2'b00, 0, 0, 0, 0, 0,
            g_rdata, g_err, g_wdata, g_strb, g_addr, lat, aw_cnt, w_cnt, saw_bus);
    chk("rstR_next_rdata", g_rdata, 32'h000000C3);

    // Misaligned word load.
    run_txn(0, 3'd2, 32'h80000001, 32'h0, 32'hA5A5A5A5, 2'b00, 0, 0, 0, 0, 0,
            g_rdata, g_err, g_wdata, g_strb, g_addr, lat, aw_cnt, w_cnt, saw_bus);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_bus", {31'd0, saw_bus}, 32'd0);
    chk("mis_latency", lat, 32'd1);
    chk("mis_err", {31'd0, g_err}, 32'd1);
    chk("mis_rdata", g_rdata, 32'd0);
`else
    chk("mis_bus", {31'd0, saw_bus}, 32'd1);
    chk("mis_latency", lat, 32'd3);
    chk("mis_err", {31'd0, g_err}, 32'd0);
    chk("mis_rdata", g_rdata, 32'hA5A5A5A5);
`endif

    for (int i = 0; i < 60; i++) begin
      bit          wen;
      logic [2:0]  op;
      logic [31:0] addr, wdata, mem;
      logic [1:0]  resp;
      wen   = $urandom_range(0, 1);
      op    = wen ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr  = $urandom;
      wdata = $urandom;
      mem   = $urandom;
      resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      model(wen, op, addr, wdata, mem, resp, e_rdata, e_err, e_wdata, e_strb, e_bus);
      run_txn(wen, op, addr, wdata, mem, resp,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              g_rdata, g_err, g_wdata, g_strb, g_addr, lat, aw_cnt, w_cnt, saw_bus);
      chk($sformatf("rnd%0d_rdata", i), g_rdata, e_rdata);
      chk($sformatf("rnd%0d_err", i), {31'd0, g_err}, {31'd0, e_err});
      chk($sformatf("rnd%0d_bus", i), {31'd0, saw_bus}, {31'd0, e_bus});
      if (e_bus) chk($sformatf("rnd%0d_addr", i), g_addr, addr);
      if (wen && e_bus) begin
        chk($sformatf("rnd%0d_wdata", i), g_wdata, e_wdata);
        chk($sformatf("rnd%0d_wstrb", i), {24'd0, g_strb}, {28'd0, e_strb});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
